// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and latency limit for mem_port_arbiter
package mem_arb_pkg;
    localparam int MEM_LAT_MAX = 4;
    localparam int CNT_W = $clog2(MEM_LAT_MAX);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between fetch and data requesters
// Ports: i_clk/i_rst (async active-low); fetch side i_if_* / o_if_* (read-only, with flush);
// data side i_d_* / o_d_* (loads and byte-enabled stores); memory side o_mem_* / i_mem_rdata.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration, otherwise data beats fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int AW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_ready,
    output logic          o_if_rvalid,
    output logic [31:0]   o_if_rdata,
    input  logic          i_if_flush,
    input  logic          i_d_req,
    input  logic [AW-1:0] i_d_addr,
    input  logic          i_d_wren,
    input  logic [3:0]    i_d_be,
    input  logic [31:0]   i_d_wdata,
    output logic          o_d_ready,
    output logic          o_d_rvalid,
    output logic [31:0]   o_d_rdata,
    output logic          o_mem_req,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_wren,
    output logic [3:0]    o_mem_be,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);
    state_t           state;
    owner_t           own;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    addr_q;
    logic             wren_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             fl_q, if_rv_q, d_rv_q;
    logic [31:0]      if_cap, if_hold, d_rdata_q;
    logic             gnt_d, gnt_if, acc, done, if_busy;

`ifdef MEM_ARB_RR_EN
    owner_t last;
    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) last <= OWN_IF;
        else if (acc) last <= o_d_ready ? OWN_D : OWN_IF;
`endif

    always_comb begin
`ifdef MEM_ARB_RR_EN
        gnt_d = i_d_req & (~i_if_req | (last == OWN_IF));
`else
        gnt_d = i_d_req;
`endif
        gnt_if = i_if_req & ~gnt_d;
    end

    // i_rst gates the readies so every output reads 0 while reset is held
    assign o_d_ready   = i_rst & (state == IDLE) & gnt_d;
    assign o_if_ready  = i_rst & (state == IDLE) & gnt_if;
    assign acc         = o_d_ready | o_if_ready;
    assign done        = (state == WAIT) && (cnt == '0);
    assign if_busy     = (state != IDLE) && (own == OWN_IF);
    assign o_mem_req   = (state == ISSUE);
    assign o_mem_addr  = o_mem_req ? addr_q : '0;
    assign o_mem_wren  = o_mem_req & wren_q;
    assign o_mem_be    = o_mem_req ? be_q : '0;
    assign o_mem_wdata = o_mem_req ? wdata_q : '0;
    // a flush in the rvalid cycle itself still kills the pulse, so o_if_rdata
    // only advances to the captured word when the pulse really appears
    assign o_if_rvalid = if_rv_q & ~i_if_flush;
    assign o_if_rdata  = o_if_rvalid ? if_cap : if_hold;
    assign o_d_rvalid  = d_rv_q;
    assign o_d_rdata   = d_rdata_q;

    always_ff @(posedge i_clk or negedge i_rst)
        if (!i_rst) begin
            state     <= IDLE;
            own       <= OWN_IF;
            cnt       <= '0;
            addr_q    <= '0;
            wren_q    <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            fl_q      <= 1'b0;
            if_rv_q   <= 1'b0;
            d_rv_q    <= 1'b0;
            if_cap    <= '0;
            if_hold   <= '0;
            d_rdata_q <= '0;
        end else begin
            if_rv_q <= done && (own == OWN_IF) && !(fl_q || i_if_flush);
            d_rv_q  <= done && (own == OWN_D);
            if (o_if_rvalid) if_hold <= if_cap;
            if (acc) fl_q <= o_if_ready & i_if_flush;
            else if (if_busy) fl_q <= fl_q | i_if_flush;
            case (state)
                IDLE:
                    if (acc) begin
                        state   <= ISSUE;
                        own     <= o_d_ready ? OWN_D : OWN_IF;
                        addr_q  <= o_d_ready ? i_d_addr : i_if_addr;
                        wren_q  <= o_d_ready & i_d_wren;
                        be_q    <= o_d_ready ? i_d_be : 4'hF;
                        wdata_q <= o_d_ready ? i_d_wdata : '0;
                    end
                ISSUE: begin
                    state <= wren_q ? IDLE : WAIT;
                    if (!wren_q) cnt <= CNT_W'(MEM_LAT - 1);
                end
                WAIT:
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (own == OWN_IF) if_cap <= i_mem_rdata;
                        else d_rdata_q <= i_mem_rdata;
                    end else cnt <= cnt - CNT_W'(1);
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, meaning cycles from o_mem_req to valid i_mem_rdata (legal 1..4).
REQ-002 SHALL have parameter AW, default 32, meaning address width; data width fixed at 32.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port i_rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have fetch-side ports i_if_req (in, 1, read request), i_if_addr (in, AW), o_if_ready (out, 1, accept), o_if_rvalid (out, 1), o_if_rdata (out, 32), i_if_flush (in, 1, discard outstanding fetch).
REQ-006 SHALL have data-side ports i_d_req (in, 1), i_d_addr (in, AW), i_d_wren (in, 1, store when high), i_d_be (in, 4, byte enables), i_d_wdata (in, 32), o_d_ready (out, 1), o_d_rvalid (out, 1), o_d_rdata (out, 32).
REQ-007 SHALL have memory-side ports o_mem_req (out, 1), o_mem_addr (out, AW), o_mem_wren (out, 1), o_mem_be (out, 4), o_mem_wdata (out, 32), i_mem_rdata (in, 32).

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, WAIT; only one transaction outstanding.
REQ-009 SHALL assert o_if_ready/o_d_ready combinationally only in IDLE, only to the granted requester; acceptance = req & ready in cycle T.
REQ-010 SHALL on acceptance register addr/wren/be/wdata/owner and go IDLE->ISSUE; non-granted requester holds its request.
REQ-011 SHALL in ISSUE drive o_mem_req=1 for exactly one cycle (T+1) with registered fields; o_mem_wren=0 for fetch.
REQ-012 SHALL for a store go ISSUE->IDLE; no rvalid pulse; next acceptance possible at T+2.
REQ-013 SHALL for a read go ISSUE->WAIT, load counter MEM_LAT-1, decrement each cycle; sample i_mem_rdata at T+1+MEM_LAT into the owner's rdata register.
REQ-014 SHALL pulse owner's rvalid for one cycle at T+2+MEM_LAT and be in IDLE that cycle (back-to-back acceptance allowed).
REQ-015 SHALL hold o_*_rdata stable between rvalid pulses; o_mem_* fields zero when o_mem_req=0.
REQ-016 SHALL suppress o_if_rvalid for an outstanding fetch if i_if_flush is high in any cycle from acceptance through the rvalid cycle inclusive; FSM timing unchanged.
REQ-017 SHALL ignore i_if_flush when no fetch outstanding; flush never affects data transactions.
REQ-018 SHALL without arbitration macro grant data over fetch when both request in IDLE.

Reset
REQ-019 SHALL on i_rst low immediately force IDLE, counter 0, all outputs 0 (ready, rvalid, rdata, o_mem_*), RR pointer to "fetch last".
REQ-020 SHALL abort any in-flight transaction on reset; late i_mem_rdata ignored; no rvalid after release until a new acceptance.

Configuration
REQ-021 SHALL with MEM_ARB_RR_EN defined grant round-robin on contention: grant the requester not granted last; pointer updates on every acceptance.
REQ-022 SHALL without MEM_ARB_RR_EN use fixed data-over-fetch priority (REQ-018) and contain no pointer flop.

Structure
REQ-023 SHALL place state enum (IDLE/ISSUE/WAIT), owner enum (OWN_IF/OWN_D) and MEM_LAT_MAX=4 in package mem_arb_pkg.
REQ-024 SHALL be a single module; no sub-module required (arbitration is one always_comb).

Verification (MEM_LAT=2)
REQ-025 Fetch read 0x100 alone, memory returns 0xDEADBEEF -> o_mem_req at T+1, o_if_rvalid=1 with 0xDEADBEEF at T+4, o_if_ready high again T+4.
REQ-026 Both request at T (no macro) -> data granted T, fetch granted at data's rvalid cycle; with MEM_ARB_RR_EN, second contention grants fetch first.
REQ-027 Store addr 0x8000_0010, be 4'b0011, wdata 0x1234 -> o_mem_req/wren/be/wdata match at T+1, no o_d_rvalid, accept possible T+2.
REQ-028 Fetch accepted T, i_if_flush at T+4 (rvalid cycle) -> o_if_rvalid stays 0; following data read returns normally.
REQ-029 i_rst low during WAIT -> all outputs 0 immediately; after release no spurious rvalid despite i_mem_rdata toggling.
